// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// pipe_ctrl_if : hazard inputs and stage-control outputs of pipe_ctrl
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_ctrl_if;
    logic       mem_wait_i;
    logic       if_wait_i;
    logic       ex_busy_i;
    logic       load_use_i;
    logic       redirect_i;
    logic       trap_i;
    logic       pc_ce_o;
    logic [1:0] pc_sel_o;
    logic       ifid_ce_o;
    logic       idex_ce_o;
    logic       exmem_ce_o;
    logic       memwb_ce_o;
    logic       ifid_flush_o;
    logic       idex_flush_o;
    logic       exmem_flush_o;
    logic       memwb_flush_o;

    // Core side: raises hazards, consumes stage controls
    modport master (
        output mem_wait_i, if_wait_i, ex_busy_i, load_use_i, redirect_i, trap_i,
        input  pc_ce_o, pc_sel_o,
        input  ifid_ce_o, idex_ce_o, exmem_ce_o, memwb_ce_o,
        input  ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o
    );

    // Controller side
    modport slave (
        input  mem_wait_i, if_wait_i, ex_busy_i, load_use_i, redirect_i, trap_i,
        output pc_ce_o, pc_sel_o,
        output ifid_ce_o, idex_ce_o, exmem_ce_o, memwb_ce_o,
        output ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o
    );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : five-stage pipeline flow controller (stall/flush/PC select).
// Optional performance counters enabled by PIPE_CTRL_PERF_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  wire              clk,
    input  wire              rst,
    pipe_ctrl_if.slave       pif
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam logic [1:0] c_PEND_NONE = 2'd0;
    localparam logic [1:0] c_PEND_RDR  = 2'd1;
    localparam logic [1:0] c_PEND_TRAP = 2'd2;

    localparam logic [1:0] c_SEL_SEQ  = 2'd0;
    localparam logic [1:0] c_SEL_RDR  = 2'd1;
    localparam logic [1:0] c_SEL_TRAP = 2'd2;

    state_t     r_state;
    logic [1:0] r_pend;

    state_t     w_state_d;
    logic [1:0] w_pend_d;
    logic       w_pc_ce;
    logic [1:0] w_pc_sel;
    logic [3:0] w_ce;       // {memwb, exmem, idex, ifid}
    logic [3:0] w_fl;
    logic       w_apply;

    always_comb begin
        w_state_d = r_state;
        w_pend_d  = r_pend;
        w_pc_ce   = 1'b0;
        w_pc_sel  = c_SEL_SEQ;
        w_ce      = 4'b0000;
        w_fl      = 4'b0000;
        w_apply   = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_ce      = 4'b1111;
                w_fl      = 4'b1111;
                w_state_d = ST_RUN;
            end

            ST_RUN: begin
                if (pif.mem_wait_i) begin
                    if (pif.trap_i || pif.redirect_i) begin
                        w_pend_d  = pif.trap_i ? c_PEND_TRAP : c_PEND_RDR;
                        w_state_d = ST_HOLD;
                    end
                end else if (pif.trap_i) begin
                    w_pc_ce   = 1'b1;
                    w_pc_sel  = c_SEL_TRAP;
                    w_ce      = 4'b1111;
                    w_fl      = 4'b1111;
                    w_apply   = 1'b1;
                    w_state_d = pif.if_wait_i ? ST_DISCARD : ST_RUN;
                end else if (pif.ex_busy_i) begin
                    w_ce = 4'b1100;
                    w_fl = 4'b0100;
                end else if (pif.redirect_i) begin
                    w_pc_ce   = 1'b1;
                    w_pc_sel  = c_SEL_RDR;
                    w_ce      = 4'b1111;
                    w_fl      = 4'b0011;
                    w_apply   = 1'b1;
                    w_state_d = pif.if_wait_i ? ST_DISCARD : ST_RUN;
                end else if (pif.load_use_i) begin
                    w_ce = 4'b1110;
                    w_fl = 4'b0010;
                end else if (pif.if_wait_i) begin
                    w_ce = 4'b1111;
                    w_fl = 4'b0001;
                end else begin
                    w_pc_ce = 1'b1;
                    w_ce    = 4'b1111;
                end
            end

            ST_HOLD: begin
                if (pif.mem_wait_i) begin
                    // A trap always outranks a redirect still waiting to be applied
                    if (pif.trap_i) begin
                        w_pend_d = c_PEND_TRAP;
                    end else if (pif.redirect_i && (r_pend != c_PEND_TRAP)) begin
                        w_pend_d = c_PEND_RDR;
                    end
                end else begin
                    w_pc_ce   = 1'b1;
                    w_ce      = 4'b1111;
                    w_apply   = 1'b1;
                    w_pend_d  = c_PEND_NONE;
                    w_state_d = pif.if_wait_i ? ST_DISCARD : ST_RUN;
                    if (r_pend == c_PEND_TRAP) begin
                        w_pc_sel = c_SEL_TRAP;
                        w_fl     = 4'b1111;
                    end else begin
                        w_pc_sel = c_SEL_RDR;
                        w_fl     = 4'b0011;
                    end
                end
            end

            ST_DISCARD: begin
                // The fetch in flight is wrong-path: keep IF/ID bubbled until it lands
                w_ce[0]   = 1'b1;
                w_fl[0]   = 1'b1;
                w_state_d = pif.if_wait_i ? ST_DISCARD : ST_RUN;
                if (pif.mem_wait_i) begin
                    if (pif.trap_i || pif.redirect_i) begin
                        w_pend_d  = pif.trap_i ? c_PEND_TRAP : c_PEND_RDR;
                        w_state_d = ST_HOLD;
                    end
                end else if (pif.trap_i) begin
                    w_pc_ce  = 1'b1;
                    w_pc_sel = c_SEL_TRAP;
                    w_ce     = 4'b1111;
                    w_fl     = 4'b1111;
                    w_apply  = 1'b1;
                end else if (pif.ex_busy_i) begin
                    w_ce[3:1] = 3'b110;
                    w_fl[3:1] = 3'b010;
                end else begin
                    w_ce[3:1] = 3'b111;
                end
            end

            default: begin
                w_state_d = ST_BOOT;
                w_pend_d  = c_PEND_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pend  <= c_PEND_NONE;
        end else begin
            r_state <= w_state_d;
            r_pend  <= w_pend_d;
        end
    end

    // Everything is held inactive while reset is asserted
    assign pif.pc_ce_o       = !rst && w_pc_ce;
    assign pif.pc_sel_o      = rst ? c_SEL_SEQ : w_pc_sel;
    assign pif.ifid_ce_o     = !rst && w_ce[0];
    assign pif.idex_ce_o     = !rst && w_ce[1];
    assign pif.exmem_ce_o    = !rst && w_ce[2];
    assign pif.memwb_ce_o    = !rst && w_ce[3];
    assign pif.ifid_flush_o  = !rst && w_fl[0];
    assign pif.idex_flush_o  = !rst && w_fl[1];
    assign pif.exmem_flush_o = !rst && w_fl[2];
    assign pif.memwb_flush_o = !rst && w_fl[3];

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((r_state != ST_BOOT) && !w_pc_ce) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_apply) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic clk;
    logic rst;
    int   n_err;
    int   n_chk;

    pipe_ctrl_if pif ();

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    pipe_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pif         (pif.slave),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
    );
`else
    pipe_ctrl #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packed view: {pc_ce, pc_sel[1:0], ce{memwb,exmem,idex,ifid}, flush{...}}
    function automatic logic [31:0] ew(input logic pce, input logic [1:0] sel,
                                       input logic [3:0] ce, input logic [3:0] fl);
        return {21'd0, pce, sel, ce, fl};
    endfunction

    function automatic logic [31:0] obs();
        return {21'd0, pif.pc_ce_o, pif.pc_sel_o,
                pif.memwb_ce_o, pif.exmem_ce_o, pif.idex_ce_o, pif.ifid_ce_o,
                pif.memwb_flush_o, pif.exmem_flush_o, pif.idex_flush_o, pif.ifid_flush_o};
    endfunction

    // Apply one cycle of inputs {mw,iw,eb,lu,rd,tr}, check outputs mid-cycle
    task automatic cyc(input string tag, input logic r, input logic [5:0] in,
                       input logic [31:0] exp);
        rst            = r;
        pif.mem_wait_i = in[5];
        pif.if_wait_i  = in[4];
        pif.ex_busy_i  = in[3];
        pif.load_use_i = in[2];
        pif.redirect_i = in[1];
        pif.trap_i     = in[0];
        @(negedge clk);
        chk(tag, obs(), exp);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] NORM, FRZ, BOOT, RDR, TRP, DSC, EXB, LDU, IFW;

    initial begin
        n_err = 0;
        n_chk = 0;
        NORM = ew(1'b1, 2'd0, 4'hF, 4'h0);
        FRZ  = ew(1'b0, 2'd0, 4'h0, 4'h0);
        BOOT = ew(1'b0, 2'd0, 4'hF, 4'hF);
        RDR  = ew(1'b1, 2'd1, 4'hF, 4'h3);
        TRP  = ew(1'b1, 2'd2, 4'hF, 4'hF);
        DSC  = ew(1'b0, 2'd0, 4'hF, 4'h1);
        EXB  = ew(1'b0, 2'd0, 4'hC, 4'h4);
        LDU  = ew(1'b0, 2'd0, 4'hE, 4'h2);
        IFW  = ew(1'b0, 2'd0, 4'hF, 4'h1);

        //              rst  {mw,iw,eb,lu,rd,tr}
        cyc("reset",    1'b1, 6'b000000, FRZ);
`ifdef PIPE_CTRL_PERF_EN
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_flush", flush_cnt, 32'd0);
`endif
        cyc("boot",     1'b0, 6'b000000, BOOT);
        cyc("idle",     1'b0, 6'b000000, NORM);

        cyc("ldu",      1'b0, 6'b000100, LDU);
        cyc("ldu_after",1'b0, 6'b000000, NORM);
`ifdef PIPE_CTRL_PERF_EN
        chk("stall_ldu", stall_cnt, 32'd1);
`endif

        // redirect blocked by a 3-cycle memory wait
        cyc("mw1_rd",   1'b0, 6'b100010, FRZ);
        cyc("mw2",      1'b0, 6'b100010, FRZ);
        cyc("mw3",      1'b0, 6'b100010, FRZ);
        cyc("mw_rel",   1'b0, 6'b000010, RDR);
        cyc("mw_after", 1'b0, 6'b000000, NORM);
`ifdef PIPE_CTRL_PERF_EN
        chk("stall_mw", stall_cnt, 32'd4);
        chk("flush_mw", flush_cnt, 32'd1);
`endif

        // trap arriving in HOLD overrides pending redirect
        cyc("hold_rd",  1'b0, 6'b100010, FRZ);
        cyc("hold_tr",  1'b0, 6'b100001, FRZ);
        cyc("hold_rel", 1'b0, 6'b000000, TRP);
        cyc("hold_aft", 1'b0, 6'b000000, NORM);

        // redirect while fetch outstanding -> DISCARD
        cyc("rd_ifw",   1'b0, 6'b010010, RDR);
        cyc("disc1",    1'b0, 6'b010000, DSC);
        cyc("disc2",    1'b0, 6'b010000, DSC);
        cyc("disc_ret", 1'b0, 6'b000000, DSC);
        cyc("disc_aft", 1'b0, 6'b000000, NORM);

        // ex_busy outranks a concurrent redirect
        cyc("exb1",     1'b0, 6'b001010, EXB);
        cyc("exb2",     1'b0, 6'b001010, EXB);
        cyc("exb3",     1'b0, 6'b001010, EXB);
        cyc("exb4",     1'b0, 6'b001010, EXB);
        cyc("exb_rd",   1'b0, 6'b000010, RDR);
        cyc("exb_aft",  1'b0, 6'b000000, NORM);

        // trap beats load_use and if_wait, then discards the fetch
        cyc("tr_ldu_iw",1'b0, 6'b010101, TRP);
        cyc("tr_disc",  1'b0, 6'b000000, DSC);
        cyc("tr_aft",   1'b0, 6'b000000, NORM);

        cyc("ifw",      1'b0, 6'b010000, IFW);
        cyc("ifw_aft",  1'b0, 6'b000000, NORM);

        // reset mid-HOLD discards the pending trap
        cyc("hold_tr2", 1'b0, 6'b100001, FRZ);
        cyc("rst_hold", 1'b1, 6'b000000, FRZ);
`ifdef PIPE_CTRL_PERF_EN
        chk("rst2_stall", stall_cnt, 32'd0);
`endif
        cyc("boot2",    1'b0, 6'b000000, BOOT);
        cyc("idle2",    1'b0, 6'b000000, NORM);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
